// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I front-end control blocks.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int CNT_W = 3;
   localparam logic [4:0] REG_X0 = 5'd0;
   typedef enum logic [1:0] {RUN, FLUSH, MDU_WAIT} fetch_ctrl_state_t;
endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// fetch_hazard_ctrl_if: ID/EX hazard inputs and fetch-stage control outputs.
interface fetch_hazard_ctrl_if #(parameter int PERF_W = 32);
   import riscv_pkg::*;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs2, ex_mem_read, ex_branch_taken, mdu_busy;
   logic [XLEN-1:0] ex_branch_target, branch_addr;
   logic pc_write, pc_src, if_id_write, flush_pipe, id_ex_bubble;
   logic [PERF_W-1:0] stall_count, flush_count;
   modport master (
      input id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, ex_branch_taken, ex_branch_target, mdu_busy,
      output pc_write, pc_src, branch_addr, if_id_write, flush_pipe, id_ex_bubble, stall_count, flush_count
   );
   modport slave (
      output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, ex_branch_taken, ex_branch_target, mdu_busy,
      input pc_write, pc_src, branch_addr, if_id_write, flush_pipe, id_ex_bubble, stall_count, flush_count
   );
endinterface

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register an EX-stage load writes.
module load_use_detect
   import riscv_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       lu
);
   assign lu = ex_mem_read && ex_rd != REG_X0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: front-end stall/flush sequencing with redirect flush window and MDU back-pressure.
module fetch_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int PERF_W = 32
) (
   input logic clk,
   input logic reset,
   fetch_hazard_ctrl_if.master bus
);
   fetch_ctrl_state_t state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [PERF_W-1:0] stall_q, flush_q;
   logic lu, pc_write, if_id_write, flush_pipe, id_ex_bubble, pc_src;
   load_use_detect u_lu (
      .id_rs1(bus.id_rs1), .id_rs2(bus.id_rs2), .id_uses_rs2(bus.id_uses_rs2),
      .ex_mem_read(bus.ex_mem_read), .ex_rd(bus.ex_rd), .lu(lu)
   );
   always_comb begin
      nxt = state;
      cnt_nxt = cnt;
      pc_write = 1'b1;
      if_id_write = 1'b1;
      flush_pipe = 1'b0;
      id_ex_bubble = 1'b0;
      pc_src = 1'b0;
      if (reset) begin
         {pc_write, if_id_write, flush_pipe, id_ex_bubble} = 4'b0011;
         nxt = RUN;
         cnt_nxt = '0;
      end else if (bus.ex_branch_taken) begin
         {pc_src, flush_pipe, id_ex_bubble} = 3'b111;
         nxt = FLUSH_CYCLES > 1 ? FLUSH : RUN;
         cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
         {flush_pipe, id_ex_bubble} = 2'b11;
         nxt = cnt == CNT_W'(1) ? RUN : FLUSH;
         cnt_nxt = cnt - CNT_W'(1);
      end else if (bus.mdu_busy) begin
         {pc_write, if_id_write} = 2'b00;
         nxt = MDU_WAIT;
      end else if (lu) begin
         {pc_write, if_id_write, id_ex_bubble} = 3'b001;
         nxt = RUN;
      end else begin
         nxt = RUN;
      end
   end
   always_ff @(posedge clk) begin
      state <= nxt;
      cnt <= cnt_nxt;
      stall_q <= reset ? '0 : stall_q + PERF_W'(!pc_write);
      flush_q <= reset ? '0 : flush_q + PERF_W'(pc_src);
   end
   assign bus.pc_write = pc_write;
   assign bus.pc_src = pc_src;
   assign bus.branch_addr = pc_src ? bus.ex_branch_target : '0;
   assign bus.if_id_write = if_id_write;
   assign bus.flush_pipe = flush_pipe;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.stall_count = stall_q;
   assign bus.flush_count = flush_q;
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed checks of stalls, redirects and flush windows on FLUSH_CYCLES=1 and 3 instances.
module tb_fetch_hazard_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   fetch_hazard_ctrl_if i1 ();
   fetch_hazard_ctrl_if i3 ();
   fetch_hazard_ctrl #(.FLUSH_CYCLES(1)) d1 (.clk(clk), .reset(reset), .bus(i1.master));
   fetch_hazard_ctrl #(.FLUSH_CYCLES(3)) d3 (.clk(clk), .reset(reset), .bus(i3.master));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic setin(input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic tk, input logic [31:0] tg, input logic mdu);
      i1.ex_mem_read = mr; i1.ex_rd = rd; i1.id_rs1 = rs1; i1.id_rs2 = rs2;
      i1.id_uses_rs2 = u2; i1.ex_branch_taken = tk; i1.ex_branch_target = tg; i1.mdu_busy = mdu;
      i3.ex_mem_read = mr; i3.ex_rd = rd; i3.id_rs1 = rs1; i3.id_rs2 = rs2;
      i3.id_uses_rs2 = u2; i3.ex_branch_taken = tk; i3.ex_branch_target = tg; i3.mdu_busy = mdu;
   endtask
   task automatic idle();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
   endtask
   initial begin
      setin(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 32'h40, 1'b1);
      step();
      chk("rst_pc_write", i1.pc_write, 1'b0);
      chk("rst_if_id", i1.if_id_write, 1'b0);
      chk("rst_flush", i1.flush_pipe, 1'b1);
      chk("rst_bubble", i1.id_ex_bubble, 1'b1);
      chk("rst_pc_src", i1.pc_src, 1'b0);
      chk("rst_baddr", i1.branch_addr, 32'h0);
      step();
      chk("rst_stall_cnt", i1.stall_count, 32'd0);
      chk("rst_flush_cnt", i1.flush_count, 32'd0);
      reset = 1'b0;
      setin(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("lu_pc_write", i1.pc_write, 1'b0);
      chk("lu_if_id", i1.if_id_write, 1'b0);
      chk("lu_bubble", i1.id_ex_bubble, 1'b1);
      step();
      idle();
      #1;
      chk("lu_release", i1.pc_write, 1'b1);
      chk("lu_stall_cnt", i1.stall_count, 32'd1);
      do_reset();
      setin(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("x0_no_stall", i1.pc_write, 1'b1);
      step();
      setin(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("rs2_unused", i1.pc_write, 1'b1);
      step();
      setin(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("rs2_used", i1.pc_write, 1'b0);
      chk("rs2_bubble", i1.id_ex_bubble, 1'b1);
      step();
      idle();
      #1;
      chk("rs2_stall_cnt", i1.stall_count, 32'd1);
      do_reset();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 32'h40, 1'b0);
      #1;
      chk("br1_pc_src", i1.pc_src, 1'b1);
      chk("br1_baddr", i1.branch_addr, 32'h40);
      chk("br1_flush", i1.flush_pipe, 1'b1);
      chk("br1_pc_write", i1.pc_write, 1'b1);
      step();
      idle();
      #1;
      chk("br1_flush_end", i1.flush_pipe, 1'b0);
      chk("br1_pc_src_end", i1.pc_src, 1'b0);
      chk("br1_baddr_end", i1.branch_addr, 32'h0);
      chk("br1_flush_cnt", i1.flush_count, 32'd1);
      do_reset();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 32'h80, 1'b0);
      #1;
      chk("br3_c1_flush", i3.flush_pipe, 1'b1);
      step();
      idle();
      #1;
      chk("br3_c2_flush", i3.flush_pipe, 1'b1);
      chk("br3_c2_pc_src", i3.pc_src, 1'b0);
      chk("br3_c2_pc_write", i3.pc_write, 1'b1);
      step();
      chk("br3_c3_flush", i3.flush_pipe, 1'b1);
      step();
      chk("br3_c4_flush", i3.flush_pipe, 1'b0);
      chk("br3_flush_cnt", i3.flush_count, 32'd1);
      do_reset();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 32'h80, 1'b0);
      #1;
      chk("rb_c1_flush", i3.flush_pipe, 1'b1);
      step();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 32'hc0, 1'b0);
      #1;
      chk("rb_c2_pc_src", i3.pc_src, 1'b1);
      chk("rb_c2_baddr", i3.branch_addr, 32'hc0);
      step();
      idle();
      #1;
      chk("rb_c3_flush", i3.flush_pipe, 1'b1);
      step();
      chk("rb_c4_flush", i3.flush_pipe, 1'b1);
      step();
      chk("rb_c5_flush", i3.flush_pipe, 1'b0);
      chk("rb_flush_cnt", i3.flush_count, 32'd2);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         setin(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
         #1;
         chk($sformatf("mdu_pc_write_%0d", k), i1.pc_write, 1'b0);
         chk($sformatf("mdu_bubble_%0d", k), i1.id_ex_bubble, 1'b0);
         step();
      end
      setin(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("mdu_lu_pc_write", i1.pc_write, 1'b0);
      chk("mdu_lu_bubble", i1.id_ex_bubble, 1'b1);
      step();
      idle();
      #1;
      chk("mdu_release", i1.pc_write, 1'b1);
      chk("mdu_stall_cnt", i1.stall_count, 32'd5);
      do_reset();
      setin(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 32'h80, 1'b0);
      step();
      idle();
      reset = 1'b1;
      #1;
      chk("midrst_flush", i3.flush_pipe, 1'b1);
      chk("midrst_pc_write", i3.pc_write, 1'b0);
      step();
      reset = 1'b0;
      #1;
      chk("postrst_flush", i3.flush_pipe, 1'b0);
      chk("postrst_pc_write", i3.pc_write, 1'b1);
      chk("postrst_flush_cnt", i3.flush_count, 32'd0);
      chk("postrst_stall_cnt", i3.stall_count, 32'd0);
      step();
      chk("postrst_run", i3.flush_pipe, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
